instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 84 ++++++++
 tb/tb_instr_fetch.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: IDLE/ARM/RUN/DONE program-run control, PC update
// with an 8-entry branch-target table, and a saturating RUN cycle counter.
module instr_fetch #(
  parameter int              PCW        = 10,
  parameter int              IW         = 9,
  parameter logic [IW-1:0]   HALT_INSTR = '1
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [IW-1:0]  InstIn,
  input  logic           isBranch,
  input  logic           BranchTaken,
  input  logic           LutWe,
  input  logic [2:0]     LutAddr,
  input  logic [PCW-1:0] LutData,
  output logic [PCW-1:0] InstAddr,
  output logic [2:0]     Opcode,
  output logic           InstValid,
  output logic           Done,
  output logic [15:0]    CycleCnt
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  state_t         r_state, w_state_nxt;
  logic [PCW-1:0] r_pc, w_pc_nxt;
  logic [15:0]    r_cnt, w_cnt_nxt;
  logic [PCW-1:0] r_lut [8];
  logic           w_halt, w_take;

  assign w_halt = (InstIn == HALT_INSTR);
  assign w_take = isBranch & BranchTaken;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < 8; i++) r_lut[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      if (LutWe) r_lut[LutAddr] <= LutData;
    end
  end

  // Branch lookup reads the registered table, so a same-cycle write is not seen.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_pc_nxt = '0;
        if (Start) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        w_pc_nxt  = '0;
        w_cnt_nxt = '0;
        if (!Start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (r_cnt != 16'hFFFF) w_cnt_nxt = r_cnt + 16'd1;
        if (Start)       w_state_nxt = S_ARM;
        else if (w_halt) w_state_nxt = S_DONE;
        else if (w_take) w_pc_nxt = r_lut[InstIn[2:0]];
        else             w_pc_nxt = r_pc + 1'b1;
      end
      S_DONE: begin
        if (Start) w_state_nxt = S_ARM;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign InstAddr  = r_pc;
  assign Opcode    = InstIn[IW-1 -: 3];
  assign InstValid = (r_state == S_RUN);
  assign Done      = (r_state == S_DONE);
  assign CycleCnt  = r_cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: run sequencing, branches, halt, wrap, LUT
// write/read ordering and mid-run reset, against hand-computed values.
module tb_instr_fetch;

  logic        Clk = 1'b0;
  logic        Reset, Start, isBranch, BranchTaken, LutWe;
  logic [8:0]  InstIn;
  logic [2:0]  LutAddr;
  logic [9:0]  LutData;
  logic [9:0]  InstAddr;
  logic [2:0]  Opcode;
  logic        InstValid, Done;
  logic [15:0] CycleCnt;

  int checks = 0;
  int errors = 0;

  instr_fetch dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InstIn(InstIn),
    .isBranch(isBranch), .BranchTaken(BranchTaken), .LutWe(LutWe),
    .LutAddr(LutAddr), .LutData(LutData), .InstAddr(InstAddr),
    .Opcode(Opcode), .InstValid(InstValid), .Done(Done), .CycleCnt(CycleCnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic instr(input logic [8:0] ins, input logic br, input logic bt);
    InstIn = ins; isBranch = br; BranchTaken = bt;
  endtask

  task automatic lutw(input logic [2:0] a, input logic [9:0] d);
    LutWe = 1'b1; LutAddr = a; LutData = d;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; LutWe = 1'b0; LutAddr = '0; LutData = '0;
    instr(9'h000, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_addr", InstAddr, 0);
    chk("rst_valid", InstValid, 0);
    chk("rst_done", Done, 0);
    chk("rst_cnt", CycleCnt, 0);

    // Arm for two cycles, loading LUT[5] meanwhile
    Reset = 1'b0; Start = 1'b1; lutw(3'd5, 10'h040);
    tick();
    LutWe = 1'b0;
    tick();
    chk("arm_valid", InstValid, 0);
    Start = 1'b0;
    tick();
    chk("run0_addr", InstAddr, 0);
    chk("run0_valid", InstValid, 1);
    tick(); chk("run1_addr", InstAddr, 1);
    tick(); chk("run2_addr", InstAddr, 2);
    tick(); chk("run3_addr", InstAddr, 3);
    chk("run3_cnt", CycleCnt, 3);

    // Not-taken branch increments, taken branch redirects, stray BranchTaken ignored
    instr(9'h005, 1'b1, 1'b0); tick(); chk("br_nt", InstAddr, 4);
    instr(9'h005, 1'b1, 1'b1); tick(); chk("br_tk", InstAddr, 10'h040);
    instr(9'h005, 1'b0, 1'b1); tick(); chk("bt_only", InstAddr, 10'h041);
    chk("cnt6", CycleCnt, 6);

    // Abort to ARM, then fresh run to a halt at PC 7
    Start = 1'b1; instr(9'h000, 1'b0, 1'b0); tick();
    chk("abort_valid", InstValid, 0);
    Start = 1'b0; tick();
    chk("rerun_addr", InstAddr, 0);
    chk("rerun_cnt", CycleCnt, 0);
    repeat (7) tick();
    chk("pc7", InstAddr, 7);
    instr(9'h1FF, 1'b1, 1'b1); #1;
    chk("op_halt", Opcode, 3'b111);
    tick();
    chk("halt_done", Done, 1);
    chk("halt_valid", InstValid, 0);
    chk("halt_addr", InstAddr, 7);
    chk("halt_cnt", CycleCnt, 8);
    tick();
    chk("done_hold_addr", InstAddr, 7);
    chk("done_hold_cnt", CycleCnt, 8);

    // Restart from DONE and exercise PC wrap via LUT[1]=3FE
    Start = 1'b1; lutw(3'd1, 10'h3FE); tick();
    LutWe = 1'b0; chk("done_to_arm", Done, 0);
    Start = 1'b0; instr(9'h001, 1'b1, 1'b1); tick();
    chk("restart_addr", InstAddr, 0);
    tick(); chk("to_3fe", InstAddr, 10'h3FE);
    instr(9'h140, 1'b0, 1'b0); #1;
    chk("op_101", Opcode, 3'b101);
    tick(); chk("to_3ff", InstAddr, 10'h3FF);
    tick(); chk("wrap", InstAddr, 0);
    chk("wrap_valid", InstValid, 1);

    // Same-cycle LUT write vs lookup uses the old entry
    lutw(3'd2, 10'h100); tick();
    chk("pc1", InstAddr, 1);
    lutw(3'd2, 10'h200); instr(9'h002, 1'b1, 1'b1); tick();
    LutWe = 1'b0;
    chk("lut_old", InstAddr, 10'h100);
    tick(); chk("lut_new", InstAddr, 10'h200);

    // Reach PC 5 through LUT[3], then reset mid-run with a taken branch pending
    lutw(3'd3, 10'h005); instr(9'h000, 1'b0, 1'b0); tick();
    LutWe = 1'b0; chk("pc201", InstAddr, 10'h201);
    instr(9'h003, 1'b1, 1'b1); tick();
    chk("pc5", InstAddr, 5);
    Reset = 1'b1; Start = 1'b1; lutw(3'd5, 10'h123); instr(9'h005, 1'b1, 1'b1); tick();
    chk("mrst_addr", InstAddr, 0);
    chk("mrst_valid", InstValid, 0);
    chk("mrst_cnt", CycleCnt, 0);
    Reset = 1'b0; LutWe = 1'b0; tick();
    Start = 1'b0; tick();
    chk("post_rst_addr", InstAddr, 0);
    tick();
    chk("lut_cleared", InstAddr, 0);
    chk("post_rst_cnt", CycleCnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1);
  end

endmodule
